// File: rtl/s420_ctrl.sv
// Command sequencer for the 16-stage cascaded counter/comparator datapath.
// Buffers {MASK, LIMIT} commands, runs the count enable until match or limit, reports hit/timeout.
module s420_ctrl #(
    parameter int TMO_W = 16,
    parameter int DEPTH = 2
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [16:0]      CMD_MASK,
    input  logic [TMO_W-1:0] CMD_LIMIT,
    output logic             P_0,
    output logic [16:0]      C,
    input  logic             Z,
    output logic             RSP_VALID,
    input  logic             RSP_READY,
    output logic             RSP_HIT,
    output logic [TMO_W-1:0] RSP_CYCLES,
    output logic             BUSY,
    output logic [1:0]       STATE_DBG
);

    // Handshakes: a transfer happens on a rising CK edge where valid and ready are both 1;
    // valid and its payload stay stable until that edge.

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = 17 + TMO_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [16:0]        c_q, c_d;
    logic [TMO_W-1:0]   limit_q, limit_d;
    logic [TMO_W-1:0]   cnt_q, cnt_d;
    logic               hit_q, hit_d;

    logic [ENT_W-1:0]   mem_q [DEPTH];
    logic [ENT_W-1:0]   mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   fill_q, fill_d;

    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [16:0]        head_mask;
    logic [TMO_W-1:0]   head_limit;
    logic [TMO_W-1:0]   cnt_inc;

    assign fifo_full  = (fill_q == CNT_W'(DEPTH));
    assign fifo_empty = (fill_q == '0);
    assign push       = CMD_VALID && !fifo_full;
    assign head_mask  = mem_q[rd_ptr_q][ENT_W-1:TMO_W];
    assign head_limit = mem_q[rd_ptr_q][TMO_W-1:0];
    assign cnt_inc    = cnt_q + TMO_W'(1);

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        limit_d = limit_q;
        cnt_d   = cnt_q;
        hit_d   = hit_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // Settle cycle: the datapath sees the new C before counting starts.
                state_d = (limit_q != '0) ? RUN : RESP;
            end
            RUN: begin
                cnt_d = cnt_inc;
                if (Z) begin
                    hit_d   = 1'b1;
                    state_d = RESP;
                end else if (cnt_inc == limit_q) begin
                    hit_d   = 1'b0;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (RSP_READY) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) begin
            c_d     = head_mask;
            limit_d = head_limit;
            cnt_d   = '0;
            hit_d   = 1'b0;
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (push) begin
            mem_d[wr_ptr_q] = {CMD_MASK, CMD_LIMIT};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            fill_d = fill_q + CNT_W'(1);
        end else if (pop && !push) begin
            fill_d = fill_q - CNT_W'(1);
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q  <= IDLE;
            c_q      <= '0;
            limit_q  <= '0;
            cnt_q    <= '0;
            hit_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            state_q  <= state_d;
            c_q      <= c_d;
            limit_q  <= limit_d;
            cnt_q    <= cnt_d;
            hit_q    <= hit_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // Entry storage needs no reset: occupancy alone defines which entries are live.
    always_ff @(posedge CK) begin
        mem_q <= mem_d;
    end

    assign CMD_READY  = !fifo_full;
    assign P_0        = (state_q == RUN);
    assign C          = c_q;
    assign RSP_VALID  = (state_q == RESP);
    assign RSP_HIT    = hit_q;
    assign RSP_CYCLES = cnt_q;
    assign BUSY       = (state_q != IDLE) || !fifo_empty;
    assign STATE_DBG  = state_q;

endmodule

// File: tb/tb_s420_ctrl.sv
// Bench for s420_ctrl: directed scenarios plus randomized commands against a Z stub and
// a reference model; responses are checked in order from an expected queue.
module tb_s420_ctrl;

    localparam int TMO_W = 16;
    localparam int W     = 17 + 1 + TMO_W;

    // ---------------- clock / reset ----------------
    logic             ck = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [16:0]      cmd_mask;
    logic [TMO_W-1:0] cmd_limit;
    logic             p_0;
    logic [16:0]      c;
    logic             z = 1'b0;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_hit;
    logic [TMO_W-1:0] rsp_cycles;
    logic             busy;
    logic [1:0]       state_dbg;

    always #5 ck = ~ck;

    s420_ctrl #(.TMO_W(TMO_W), .DEPTH(2)) dut (
        .CK(ck), .RST(rst),
        .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
        .CMD_MASK(cmd_mask), .CMD_LIMIT(cmd_limit),
        .P_0(p_0), .C(c), .Z(z),
        .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready),
        .RSP_HIT(rsp_hit), .RSP_CYCLES(rsp_cycles),
        .BUSY(busy), .STATE_DBG(state_dbg)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int           hit_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;
    int           p0_cnt   = 0;
    int           run_cnt  = 0;
    bit           rand_rdy = 0;
    bit           hold     = 0;
    logic         h_hit;
    logic [TMO_W-1:0] h_cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference: a command reports the first enabled cycle with a match, else its limit.
    function automatic logic [W-1:0] model(input logic [16:0] m, input logic [TMO_W-1:0] l,
                                           input int h);
        bit hit;
        int cyc;
        if (l == 0) begin
            hit = 0; cyc = 0;
        end else if (h >= 1 && h <= int'(l)) begin
            hit = 1; cyc = h;
        end else begin
            hit = 0; cyc = int'(l);
        end
        return {m, hit, TMO_W'(cyc)};
    endfunction

    // ---------------- datapath Z stub ----------------
    always @(posedge ck) begin
        if (rst || (rsp_valid && rsp_ready)) run_cnt <= 0;
        else if (p_0) run_cnt <= run_cnt + 1;
    end

    always @(posedge ck) begin
        #2;
        if (p_0) z = (hit_q.size() > 0 && hit_q[0] != 0 && run_cnt + 1 == hit_q[0]);
        else     z = 1'($urandom_range(0, 1));
    end

    // ---------------- monitor ----------------
    always @(negedge ck) begin
        if (rst) begin
            p0_cnt = 0;
            hold   = 0;
        end else begin
            if (hold) begin
                chk("rsp_hold_valid", rsp_valid, 1);
                chk("rsp_hold_data", {rsp_hit, rsp_cycles}, {h_hit, h_cyc});
            end
            if (p_0) p0_cnt++;
            if (rsp_valid && rsp_ready) begin
                hold = 0;
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    chk("rsp_hit", rsp_hit, e[TMO_W]);
                    chk("rsp_cycles", rsp_cycles, e[TMO_W-1:0]);
                    chk("c_mask", c, e[W-1:TMO_W+1]);
                    chk("p0_cycles", p0_cnt, e[TMO_W-1:0]);
                    if (hit_q.size() > 0) void'(hit_q.pop_front());
                end
                p0_cnt = 0;
            end else if (rsp_valid) begin
                hold  = 1;
                h_hit = rsp_hit;
                h_cyc = rsp_cycles;
            end else begin
                hold = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge ck);
        #1;
        if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic push_cmd(input logic [16:0] m, input logic [TMO_W-1:0] l, input int h);
        bit done = 0;
        cmd_valid = 1; cmd_mask = m; cmd_limit = l;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge ck);
            if (cmd_ready) begin
                exp_q.push_back(model(m, l, h));
                hit_q.push_back(h);
                done = 1;
            end
            tick();
        end
        cmd_valid = 0;
        if (!done) chk("push_timeout", 0, 1);
    endtask

    task automatic try_push(input logic [16:0] m, input logic [TMO_W-1:0] l, input int h,
                            output bit acc);
        cmd_valid = 1; cmd_mask = m; cmd_limit = l;
        @(negedge ck);
        acc = cmd_ready;
        if (acc) begin
            exp_q.push_back(model(m, l, h));
            hit_q.push_back(h);
        end
        tick();
    endtask

    task automatic drain();
        rsp_ready = 1;
        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0 && !busy) break;
            tick();
        end
        chk("drain_empty", exp_q.size(), 0);
        chk("drain_idle", busy, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int  n;
        int  acc_cnt;
        bit  acc;
        bit  reached;
        rst = 1; cmd_valid = 0; cmd_mask = '0; cmd_limit = '0; rsp_ready = 0;
        repeat (2) @(posedge ck);
        @(negedge ck);
        chk("rst_p0", p_0, 0);
        chk("rst_c", c, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_data", {rsp_hit, rsp_cycles}, 0);
        chk("rst_state", state_dbg, 0);
        @(posedge ck); #1;
        rst = 0;

        // hit on the 4th enabled cycle
        rsp_ready = 1;
        push_cmd(17'h00001, 10, 4);
        drain();

        // timeout, then a match exactly on the limit cycle
        push_cmd(17'h1F0F0, 5, 0);
        push_cmd(17'h0AAAA, 5, 5);
        drain();

        // zero limit: response two cycles after the pop, no enable
        push_cmd(17'h12345, 0, 1);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge ck);
            n++;
            if (rsp_valid) break;
        end
        chk("zero_lim_latency", n, 3);
        tick();
        drain();

        // backpressure: four back-to-back offers with responses stalled
        rsp_ready = 0;
        acc_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            try_push(17'($urandom), TMO_W'(3 + i), 0, acc);
            acc_cnt += int'(acc);
        end
        cmd_valid = 0;
        chk("bp_accepted", acc_cnt, 3);
        @(negedge ck);
        chk("bp_cmd_ready", cmd_ready, 0);
        chk("bp_busy", busy, 1);
        tick();
        repeat (15) tick();
        drain();

        // reset during the 3rd enabled cycle of a limit-8 command
        push_cmd(17'h0F00F, 8, 0);
        n = 0;
        reached = 0;
        for (int i = 0; i < 40 && !reached; i++) begin
            @(negedge ck);
            if (p_0) n++;
            if (n == 3) reached = 1;
        end
        chk("rst_run_reached", reached, 1);
        rst = 1;
        @(posedge ck); #1;
        exp_q.delete();
        hit_q.delete();
        @(negedge ck);
        chk("rrun_p0", p_0, 0);
        chk("rrun_rsp_valid", rsp_valid, 0);
        chk("rrun_busy", busy, 0);
        chk("rrun_cmd_ready", cmd_ready, 1);
        @(posedge ck); #1;
        rst = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge ck);
            chk("rrun_quiet", {p_0, rsp_valid, busy}, 0);
        end
        tick();

        // randomized commands with random response backpressure
        rand_rdy = 1;
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 2)) tick();
            push_cmd(17'($urandom), TMO_W'($urandom_range(0, 12)), int'($urandom_range(0, 14)));
        end
        rand_rdy = 0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
